// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared single-port instruction/data memory.
// Fetch and load/store take turns, and each read response goes back to its owner.
module mem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_gnt,
    output logic              o_dm_rvalid,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    localparam logic [3:0] LP_MAX = 4'(MAX_DM_STREAK);

    owner_e      r_owner;
    owner_e      w_owner_nxt;
    logic [3:0]  r_streak;
    logic [3:0]  w_streak_nxt;
    logic        w_if_gnt;
    logic        w_dm_gnt;
    logic        w_if_starved;

    assign w_if_starved = i_if_req && (r_streak == LP_MAX);

    // Pick the winner: DM first, unless fetch has waited long enough
    always_comb begin
        w_if_gnt = 1'b0;
        w_dm_gnt = 1'b0;
        if (i_rst_n) begin
            if (i_dm_req && !w_if_starved) begin
                w_dm_gnt = 1'b1;
            end else if (i_if_req) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    assign o_if_gnt = w_if_gnt;
    assign o_dm_gnt = w_dm_gnt;

    // Present the winner's access to the memory; all zeros when idle
    always_comb begin
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        if (w_dm_gnt) begin
            o_mem_addr  = i_dm_addr;
            o_mem_we    = i_dm_we;
            o_mem_wdata = i_dm_wdata;
        end else if (w_if_gnt) begin
            o_mem_addr  = i_if_addr;
        end
    end

    // Next owner and DM streak length
    always_comb begin
        w_owner_nxt  = OWN_NONE;
        w_streak_nxt = r_streak;
        if (w_dm_gnt) begin
            w_owner_nxt = OWN_DM;
        end else if (w_if_gnt) begin
            w_owner_nxt = OWN_IF;
        end
        if (w_dm_gnt && i_if_req) begin
            if (r_streak != LP_MAX) begin
                w_streak_nxt = r_streak + 4'd1;
            end
        end else if (w_if_gnt || !i_if_req) begin
            w_streak_nxt = 4'd0;
        end
    end

    // Owner and streak registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner  <= OWN_NONE;
            r_streak <= 4'd0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    assign o_if_rvalid = (r_owner == OWN_IF);
    assign o_dm_rvalid = (r_owner == OWN_DM);
    assign o_if_rdata  = i_mem_rdata;
    assign o_dm_rdata  = i_mem_rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port, 1024x32 synchronous-read data/instruction memory between two requesters: instruction fetch (IF) and load/store (DM).
- Arbitrates one access per cycle and drives the memory's address, write-enable and write-data inputs.
- Routes the memory's registered read data back to the requester that owned the access one cycle earlier.
- Sits between the core's fetch/LSU stages and the memory macro.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- MAX_DM_STREAK, 4, maximum consecutive DM grants while IF is requesting before IF is forced through. Legal range 1..15.

Ports:
- i_clk  in  1  system clock, rising-edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_if_req  in  1  fetch request. Held high until granted.
- i_if_addr  in  ADDR_W  fetch byte address.
- o_if_gnt  out  1  fetch accepted this cycle. Combinational.
- o_if_rvalid  out  1  fetch read data valid. Registered.
- o_if_rdata  out  DATA_W  fetch read data.
- i_dm_req  in  1  data request. Held high until granted.
- i_dm_we  in  1  1 = store, 0 = load.
- i_dm_addr  in  ADDR_W  data byte address.
- i_dm_wdata  in  DATA_W  store data.
- o_dm_gnt  out  1  data accepted this cycle. Combinational.
- o_dm_rvalid  out  1  data response valid, for loads and stores. Registered.
- o_dm_rdata  out  DATA_W  load data. For a store: pre-write word contents.
- o_mem_addr  out  ADDR_W  to memory address input.
- o_mem_we  out  1  to memory write enable.
- o_mem_wdata  out  DATA_W  to memory write data.
- i_mem_rdata  in  DATA_W  from memory. Valid one cycle after the address is presented.

Behaviour:
- Clock/reset: single clock i_clk. Reset i_rst_n is asynchronous, active-low.
- While i_rst_n is low:
  - o_if_gnt = o_dm_gnt = 0, o_mem_we = 0, o_mem_addr = 0, o_mem_wdata = 0.
  - o_if_rvalid = o_dm_rvalid = 0.
  - Internal owner register = NONE; streak counter = 0.
- Arbitration (combinational, every cycle):
  - Only DM requesting: grant DM.
  - Only IF requesting: grant IF.
  - Both requesting: grant DM unless streak == MAX_DM_STREAK, in which case grant IF.
  - Neither requesting: no grant; o_mem_we = 0, o_mem_addr = 0, o_mem_wdata = 0.
- At most one of o_if_gnt / o_dm_gnt is high in any cycle. A grant is never issued without the matching request.
- Memory drive, in the grant cycle:
  - o_mem_addr = winner's address, passed unmodified.
  - o_mem_we = i_dm_we if DM wins, else 0.
  - o_mem_wdata = i_dm_wdata if DM wins, else 0.
- Streak counter (4 bits), updated at the clock edge:
  - DM granted while i_if_req high: increment, saturating at MAX_DM_STREAK.
  - IF granted, or i_if_req low: clear to 0.
- Response path:
  - Owner register captures IF / DM / NONE at each edge, from the grant.
  - Next cycle, o_if_rvalid = (owner == IF) and o_dm_rvalid = (owner == DM).
  - o_if_rdata and o_dm_rdata both = i_mem_rdata unconditionally. Data is meaningful only while the matching rvalid is high.
- Latency:
  - Grant in cycle N, response in cycle N+1.
  - Back-to-back grants give one response every cycle, full throughput, no bubbles.
- Store response:
  - o_dm_rvalid pulses in N+1.
  - o_dm_rdata = word contents before the write (the memory reads before it writes).
- Same-address ordering: a DM store in cycle N followed by an IF or DM read of the same word in N+1 returns the new data.
- Requester rules:
  - A requester must keep its request and address stable until it sees its grant.
  - The arbiter holds no pending request state beyond the owner register. No buffering, no backpressure on responses.
- Reset mid-operation: an access granted in the cycle reset asserts produces no rvalid. The owner register clears asynchronously.
- Reset release: first grants are possible in the first cycle i_rst_n is high, combinationally.

Test Plan:
- IF only, i_if_addr = 0x0, 0x4, 0x8 on consecutive cycles -> o_if_gnt high all three cycles; o_if_rvalid high cycles 2-4 with preloaded words 0x0, 0x4, 0x8 in order; o_dm_rvalid stays 0.
- DM store 0xDEADBEEF to 0x10, then DM load 0x10 next cycle -> store response rdata = old word; load response rdata = 0xDEADBEEF; o_mem_we high only in the store cycle.
- IF and DM both requesting continuously for 12 cycles, MAX_DM_STREAK = 4 -> grant pattern DM,DM,DM,DM,IF repeating; never 5 consecutive DM grants; responses routed to the matching rvalid one cycle later.
- DM requesting every cycle, IF idle -> DM granted every cycle; streak stays 0; IF never granted.
- Assert i_rst_n low in the same cycle as a DM load grant -> gnt, mem_we and both rvalids 0 immediately and in the following cycle. After release, a new IF request at 0x20 is granted at once and returns the word at 0x20 one cycle later.
- No requests for 5 cycles -> both gnt and both rvalid 0, o_mem_we = 0, o_mem_addr = 0 every cycle.
